// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, handshake FSM states,
// and the classifier that routes opcodes to the iterative multiply/divide unit.
package seq_alu_pkg;

  localparam int OP_BITS = 5;
  typedef logic [OP_BITS-1:0] op_t;

  localparam op_t OP_ADD   = 5'd0;
  localparam op_t OP_SUB   = 5'd1;
  localparam op_t OP_SLL   = 5'd2;
  localparam op_t OP_SLT   = 5'd3;
  localparam op_t OP_SLTU  = 5'd4;
  localparam op_t OP_XOR   = 5'd5;
  localparam op_t OP_OR    = 5'd6;
  localparam op_t OP_AND   = 5'd7;
  localparam op_t OP_SRL   = 5'd8;
  localparam op_t OP_SRA   = 5'd9;
  localparam op_t OP_MUL   = 5'd10;
  localparam op_t OP_MULH  = 5'd11;
  localparam op_t OP_MULHU = 5'd12;
  localparam op_t OP_DIV   = 5'd13;
  localparam op_t OP_DIVU  = 5'd14;
  localparam op_t OP_REM   = 5'd15;
  localparam op_t OP_REMU  = 5'd16;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  function automatic logic is_iterative(op_t op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative multiply/divide: operands reduced to magnitudes on start, WIDTH
// shift-add or restoring-subtract steps, then a combinational sign fixup.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               active;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;      // mul: {product hi, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opd;      // multiplicand or divisor magnitude
  op_t                op_q;
  logic               neg_p, neg_a, div_zero;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic               is_div;

  assign signed_op = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_abs     = a_neg ? -a : a;
  assign b_abs     = b_neg ? -b : b;
  assign is_div    = (op_q >= OP_DIV);

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_diff;
  logic [2*WIDTH-1:0] step_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff = rem_sh[WIDTH-1:0] - opd;
    if (!is_div)
      step_next = {mul_sum, acc[WIDTH-1:1]};
    else if (rem_sh >= {1'b0, opd})
      step_next = {rem_diff, acc[WIDTH-2:0], 1'b1};
    else
      step_next = {acc[2*WIDTH-2:0], 1'b0};
  end

  assign done = active && (cnt == CW'(WIDTH));

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  assign prod = neg_p ? -acc : acc;
  assign quo  = acc[WIDTH-1:0];
  assign rem  = acc[2*WIDTH-1:WIDTH];

  // Divide-by-zero keeps the all-ones quotient unsigned; the overflow case
  // (MIN / -1) falls out naturally since |MIN| reads back as MIN.
  always_comb begin
    result = '0;
    case (op_q)
      OP_MUL:   result = prod[WIDTH-1:0];
      OP_MULH:  result = prod[2*WIDTH-1:WIDTH];
      OP_MULHU: result = rem;
      OP_DIV:   result = (neg_p && !div_zero) ? -quo : quo;
      OP_DIVU:  result = quo;
      OP_REM:   result = neg_a ? -rem : rem;
      OP_REMU:  result = rem;
      default:  result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      opd      <= '0;
      op_q     <= OP_ADD;
      neg_p    <= 1'b0;
      neg_a    <= 1'b0;
      div_zero <= 1'b0;
    end else if (start) begin
      active   <= 1'b1;
      cnt      <= '0;
      acc      <= {{WIDTH{1'b0}}, a_abs};
      opd      <= b_abs;
      op_q     <= op;
      neg_p    <= a_neg ^ b_neg;
      neg_a    <= a_neg;
      div_zero <= (b == '0);
    end else if (active) begin
      if (done) begin
        active <= 1'b0;
      end else begin
        acc <= step_next;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU: valid/ready handshake FSM, single-cycle
// datapath, registered result, and the iterative unit for MUL*/DIV*/REM*.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OPW-1:0]   opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  logic             up;         // low for the first cycle out of reset
  logic             accept;
  op_t              op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_y;
  logic             alu_ill;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  assign op        = op_t'(opcode);
  assign shamt     = B[SHW-1:0];
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_BUSY);
  assign in_ready  = up && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    alu_y   = '0;
    alu_ill = 1'b0;
    case (op)
      OP_ADD:  alu_y = A + B;
      OP_SUB:  alu_y = A - B;
      OP_SLL:  alu_y = A << shamt;
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, A < B};
      OP_XOR:  alu_y = A ^ B;
      OP_OR:   alu_y = A | B;
      OP_AND:  alu_y = A & B;
      OP_SRL:  alu_y = A >> shamt;
      OP_SRA:  alu_y = $signed(A) >>> shamt;
      default: alu_ill = !is_iterative(op);
    endcase
  end

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && is_iterative(op)),
    .op     (op),
    .a      (A),
    .b      (B),
    .done   (md_done),
    .result (md_result)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      up      <= 1'b0;
      Y       <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
    end else begin
      up <= 1'b1;
      case (state)
        S_BUSY: begin
          if (md_done) begin
            state   <= S_DONE;
            Y       <= md_result;
            zero    <= (md_result == '0);
            illegal <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            if (is_iterative(op)) begin
              state <= S_BUSY;
            end else begin
              state   <= S_DONE;
              Y       <= alu_y;
              zero    <= (alu_y == '0);
              illegal <= alu_ill;
            end
          end else if ((state == S_DONE) && out_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed vector table, reset and
// backpressure sequences, and a randomized pass against a behavioural model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [4:0]  opcode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] Y;
  logic        zero;
  logic        illegal;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32), .OPW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .zero      (zero),
    .illegal   (illegal),
    .busy      (busy)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] y, output logic z, output logic ill,
                        output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    opcode = op; A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    // scramble inputs after accept: the result must come from captured operands
    in_valid = 1'b0; A = $urandom; B = $urandom; opcode = 5'd11;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    y = Y; z = zero; ill = illegal;
  endtask

  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] y, output logic ill);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    logic [31:0]        mn;
    mn  = 32'h8000_0000;
    ps  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    pu  = {32'b0, a} * {32'b0, b};
    ill = 1'b0;
    y   = '0;
    case (op)
      5'd0:  y = a + b;
      5'd1:  y = a - b;
      5'd2:  y = a << b[4:0];
      5'd3:  y = {31'b0, $signed(a) < $signed(b)};
      5'd4:  y = {31'b0, a < b};
      5'd5:  y = a ^ b;
      5'd6:  y = a | b;
      5'd7:  y = a & b;
      5'd8:  y = a >> b[4:0];
      5'd9:  y = $signed(a) >>> b[4:0];
      5'd10: y = pu[31:0];
      5'd11: y = ps[63:32];
      5'd12: y = pu[63:32];
      5'd13: y = (b == 0) ? 32'hFFFF_FFFF : (a == mn && b == 32'hFFFF_FFFF) ? mn
                 : 32'($signed(a) / $signed(b));
      5'd14: y = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd15: y = (b == 0) ? a : (a == mn && b == 32'hFFFF_FFFF) ? 32'h0
                 : 32'($signed(a) % $signed(b));
      5'd16: y = (b == 0) ? a : a % b;
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [6];
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    logic [31:0] y, ey;
    logic        z, ill, eill;
    int          lat, cnt;

    vecs.push_back('{5'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1});
    vecs.push_back('{5'd1,  32'h5,         32'h5,         32'h0,         1'b0, 1});
    vecs.push_back('{5'd2,  32'h1,         32'h3F,        32'h8000_0000, 1'b0, 1});
    vecs.push_back('{5'd3,  32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1});
    vecs.push_back('{5'd4,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1});
    vecs.push_back('{5'd5,  32'hF0F0,      32'hFF00,      32'h0FF0,      1'b0, 1});
    vecs.push_back('{5'd6,  32'hF0F0,      32'hFF00,      32'hFFF0,      1'b0, 1});
    vecs.push_back('{5'd7,  32'hF0F0,      32'hFF00,      32'hF000,      1'b0, 1});
    vecs.push_back('{5'd8,  32'h8000_0000, 32'h4,         32'h0800_0000, 1'b0, 1});
    vecs.push_back('{5'd9,  32'h8000_0000, 32'h4,         32'hF800_0000, 1'b0, 1});
    vecs.push_back('{5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b0, 34});
    vecs.push_back('{5'd10, 32'h7,         32'h6,         32'h2A,        1'b0, 34});
    vecs.push_back('{5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b0, 34});
    vecs.push_back('{5'd11, 32'h8000_0000, 32'h2,         32'hFFFF_FFFF, 1'b0, 34});
    vecs.push_back('{5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 34});
    vecs.push_back('{5'd13, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 1'b0, 34});
    vecs.push_back('{5'd15, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 1'b0, 34});
    vecs.push_back('{5'd13, 32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 34});
    vecs.push_back('{5'd15, 32'h7,         32'hFFFF_FFFE, 32'h1,         1'b0, 34});
    vecs.push_back('{5'd14, 32'd100,       32'h0,         32'hFFFF_FFFF, 1'b0, 34});
    vecs.push_back('{5'd16, 32'd100,       32'h0,         32'd100,       1'b0, 34});
    vecs.push_back('{5'd13, 32'h5,         32'h0,         32'hFFFF_FFFF, 1'b0, 34});
    vecs.push_back('{5'd15, 32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB, 1'b0, 34});
    vecs.push_back('{5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 34});
    vecs.push_back('{5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, 34});
    vecs.push_back('{5'd14, 32'd100,       32'd7,         32'd14,        1'b0, 34});
    vecs.push_back('{5'd16, 32'd100,       32'd7,         32'd2,         1'b0, 34});
    vecs.push_back('{5'd31, 32'h1234,      32'h5678,      32'h0,         1'b1, 1});
    vecs.push_back('{5'd17, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1});

    // reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready",  {31'b0, in_ready},  32'h0);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_y",         Y,                  32'h0);
    check("rst_zero",      {31'b0, zero},      32'h1);
    check("rst_illegal",   {31'b0, illegal},   32'h0);
    check("rst_busy",      {31'b0, busy},      32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'h1);

    // directed vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, y, z, ill, lat);
      check($sformatf("vec%0d_y", i),       y,               vecs[i].y);
      check($sformatf("vec%0d_zero", i),    {31'b0, z},      {31'b0, vecs[i].y == 32'h0});
      check($sformatf("vec%0d_illegal", i), {31'b0, ill},    {31'b0, vecs[i].ill});
      check($sformatf("vec%0d_latency", i), 32'(lat),        32'(vecs[i].lat));
    end

    // reset in the middle of a divide
    @(posedge clk); #1;
    opcode = 5'd13; A = 32'hFFFF_FFF9; B = 32'h2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("middiv_busy", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("middiv_rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("middiv_rst_busy",      {31'b0, busy},      32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("middiv_in_ready", {31'b0, in_ready}, 32'h1);
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || busy) cnt++;
    end
    check("middiv_no_result", 32'(cnt), 32'h0);

    // backpressure: result held, then a new op accepted in the release cycle
    out_ready = 1'b0;
    opcode = 5'd6; A = 32'hF0F0; B = 32'hFF00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_first_valid", {31'b0, out_valid}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_y", k),        Y,                  32'hFFF0);
      check($sformatf("bp_hold%0d_valid", k),    {31'b0, out_valid}, 32'h1);
      check($sformatf("bp_hold%0d_in_ready", k), {31'b0, in_ready},  32'h0);
    end
    opcode = 5'd7; A = 32'hF0F0; B = 32'hFF00; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_valid", {31'b0, out_valid}, 32'h1);
    check("bp_next_y",     Y,                  32'hF000);

    // randomized ops against the behavioural model
    for (int n = 0; n < 300; n++) begin
      logic [4:0]  rop;
      logic [31:0] ra, rb;
      int          elat;
      rop = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) rop = 5'($urandom_range(0, 16));
      ra = pick_operand();
      rb = pick_operand();
      model(rop, ra, rb, ey, eill);
      elat = (rop >= 5'd10 && rop <= 5'd16) ? 34 : 1;
      run_op(rop, ra, rb, y, z, ill, lat);
      check($sformatf("rand%0d_op%0d_%h_%h", n, rop, ra, rb),
            {y[30:0], 1'b0} ^ {31'b0, ill} ^ y, {ey[30:0], 1'b0} ^ {31'b0, eill} ^ ey);
      check($sformatf("rand%0d_y", n),   y,                      ey);
      check($sformatf("rand%0d_lat", n), 32'(lat),               32'(elat));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
